// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter: one owner at a time drives the shared 8:1 select, and the owner's data bit is returned registered.
// Optional forced release after HOLD_MAX grant cycles is compiled in with `define HOLD_TIMEOUT_EN.
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Req,
    input  logic       Done,
    input  logic [7:0] I,
    output logic [2:0] S,
    output logic [7:0] Grant,
    output logic       Busy,
    output logic       Y,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       y_q, y_d;
    logic       timeout_q, timeout_d;

    logic [2:0] win_s;
    logic       win_vld_s;
    logic       owner_req_s;
    logic       hold_exp_s;
    logic       release_s;
    logic [2:0] idx_s;

    // First requester at or after ptr_q, searching upward with wrap.
    always_comb begin
        win_s     = ptr_q;
        win_vld_s = 1'b0;
        idx_s     = ptr_q;
        for (int k = 0; k < 8; k++) begin
            idx_s = ptr_q + 3'(k);
            if (!win_vld_s && Req[idx_s]) begin
                win_vld_s = 1'b1;
                win_s     = idx_s;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    assign owner_req_s = Req[s_q];

`ifdef HOLD_TIMEOUT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    logic [CW-1:0] hold_q, hold_d;

    // Hold counter: zero on the first grant cycle, counting grant cycles.
    always_comb begin
        hold_d = '0;
        if (state_q == ST_GRANT) begin
            hold_d = hold_q + CW'(1);
        end else begin
            hold_d = '0;
        end
    end

    // Hold counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // The HOLD_MAX-th grant cycle is the last one allowed.
    assign hold_exp_s = (state_q == ST_GRANT) && (hold_q == HOLD_LAST);
`else
    assign hold_exp_s = 1'b0;
`endif

    assign release_s = Done || !owner_req_s || hold_exp_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        y_d       = (state_q == ST_GRANT) ? I[s_q] : 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_d = ST_GRANT;
                    s_d     = win_s;
                    grant_d = 8'b0000_0001 << win_s;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 8'h00;
                    busy_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_d   = ST_GAP;
                    grant_d   = 8'h00;
                    busy_d    = 1'b0;
                    ptr_d     = s_q + 3'd1;
                    // A same-cycle Done makes this an ordinary release.
                    timeout_d = hold_exp_s && !Done;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                grant_d = 8'h00;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'h00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            s_q       <= 3'd0;
            ptr_q     <= 3'd0;
            grant_q   <= 8'h00;
            busy_q    <= 1'b0;
            y_q       <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            y_q       <= y_d;
            timeout_q <= timeout_d;
        end
    end

    assign S       = s_q;
    assign Grant   = grant_q;
    assign Busy    = busy_q;
    assign Y       = y_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios plus random traffic against a behavioural owner/pointer model.
module tb_mux8_rr_arbiter;

    localparam int HOLD_MAX = 15;
    localparam int CW       = 4;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Req   = 8'h00;
    logic       Done  = 1'b0;
    logic [7:0] I     = 8'h00;
    logic [2:0] S;
    logic [7:0] Grant;
    logic       Busy;
    logic       Y;
    logic       Timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Done(Done), .I(I),
        .S(S), .Grant(Grant), .Busy(Busy), .Y(Y), .Timeout(Timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: owner index (-1 = none), dead-cycle flag, search pointer.
    int         m_owner = -1;
    bit         m_gap   = 1'b0;
    int         m_ptr   = 0;
    int         m_hold  = 0;
    int         m_last  = 0;
    bit         m_valid = 1'b0;
    bit         m_forced;
    logic       m_ny;
    logic [2:0] e_S     = 3'd0;
    logic [7:0] e_Grant = 8'h00;
    logic       e_Busy  = 1'b0;
    logic       e_Y     = 1'b0;
    logic       e_To    = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_hold = 0; m_last = 0;
            m_ny = 1'b0; e_To = 1'b0; m_valid = 1'b1;
        end else begin
            m_ny = (m_owner >= 0) ? I[m_owner] : 1'b0;
            e_To = 1'b0;
            if (m_owner >= 0) begin
                m_hold++;
                m_forced = 1'b0;
`ifdef HOLD_TIMEOUT_EN
                m_forced = (m_hold >= HOLD_MAX) && !Done;
`endif
                if (Done || !Req[m_owner] || m_forced) begin
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_gap   = 1'b1;
                    e_To    = m_forced;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (Req != 8'h00) begin
                for (int k = 0; k < 8; k++)
                    if (m_owner < 0 && Req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                m_last = m_owner;
                m_hold = 0;
            end
        end
        e_Y     = m_ny;
        e_S     = m_last[2:0];
        e_Grant = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e_Busy  = (m_owner >= 0);
    end

    // Per-cycle compare against the model, plus a log of DUT grant starts.
    logic [7:0] prev_grant = 8'h00;
    int         glog[$];

    always @(negedge Clk) begin
        if (m_valid) begin
            check("S", S, e_S);
            check("Grant", Grant, e_Grant);
            check("Busy", Busy, e_Busy);
            check("Y", Y, e_Y);
            check("Timeout", Timeout, e_To);
            check("onehot", ($countones(Grant) <= 1), 1);
            check("grant_busy", (Grant != 8'h00), Busy);
            if (Grant != 8'h00 && prev_grant == 8'h00)
                for (int k = 0; k < 8; k++) if (Grant[k]) glog.push_back(k);
            prev_grant = Grant;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_busy(input string name);
        int t = 0;
        while (!Busy && t < 40) begin
            @(negedge Clk);
            t++;
        end
        check(name, Busy, 1);
    endtask

    task automatic run_grants(input int n);
        for (int g = 0; g < n; g++) begin
            wait_busy("grant_wait");
            Done = 1'b1;
            cyc(1);
            Done = 1'b0;
        end
    endtask

    task automatic log_at(input string name, input int pos, input int exp);
        check(name, (glog.size() > pos) ? glog[pos] : -1, exp);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
    endtask

    initial begin
        int cnt;
        // Reset with all requests high
        Reset = 1'b1; Req = 8'hFF;
        cyc(2);
        check("rst_S", S, 0);
        check("rst_Grant", Grant, 0);
        check("rst_Busy", Busy, 0);
        check("rst_Y", Y, 0);
        check("rst_Timeout", Timeout, 0);

        // Single requester 2 with its data bit high
        Reset = 1'b0; Req = 8'h04; I = 8'h04;
        cyc(1);
        check("t2_Grant", Grant, 8'h04);
        check("t2_S", S, 2);
        check("t2_Busy", Busy, 1);
        cyc(1);
        check("t2_Y", Y, 1);
        Req = 8'h00;
        cyc(4);

        // Full rotation with wrap
        do_reset();
        glog.delete();
        Req = 8'hFF;
        run_grants(9);
        check("t3_count", glog.size(), 9);
        for (int i = 0; i < 9; i++) log_at("t3_order", i, i % 8);
        Req = 8'h00;
        cyc(3);

        // Pointer at 5 after owner 4: 0 wins before 4
        do_reset();
        glog.delete();
        Req = 8'h10;
        run_grants(1);
        Req = 8'h11;
        run_grants(2);
        Req = 8'h00;
        cyc(3);
        log_at("t4_first", 0, 4);
        log_at("t4_second", 1, 0);
        log_at("t4_third", 2, 4);

`ifdef HOLD_TIMEOUT_EN
        // Forced release after HOLD_MAX cycles
        do_reset();
        Req = 8'h08; Done = 1'b0;
        wait_busy("t5_wait");
        cnt = 0;
        while (Busy && cnt < 40) begin
            cnt++;
            cyc(1);
        end
        check("t5_hold", cnt, HOLD_MAX);
        check("t5_to_pulse", Timeout, 1);
        cyc(1);
        check("t5_to_end", Timeout, 0);
        wait_busy("t5_regrant_wait");
        check("t5_regrant", Grant, 8'h08);
        Req = 8'h00;
        cyc(3);
`endif

        // Reset in the middle of a grant to 6
        do_reset();
        Req = 8'h40;
        wait_busy("t6_wait");
        check("t6_owner", Grant, 8'h40);
        Reset = 1'b1;
        cyc(1);
        check("t6_rst_Grant", Grant, 0);
        check("t6_rst_Y", Y, 0);
        Reset = 1'b0; Req = 8'hC1;
        wait_busy("t6_after_wait");
        check("t6_after", Grant, 8'h01);
        Req = 8'h00;
        cyc(3);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) Req = 8'($urandom);
            Done  = ($urandom_range(0, 5) == 0);
            I     = 8'($urandom);
            Reset = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        Reset = 1'b0; Done = 1'b0; Req = 8'h00;
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
